// File: rtl/seq_detect_param.sv
// Serial sequence detector: matches the last PAT_W valid bits of a stream against a
// runtime-loadable pattern, with overlapping/non-overlapping modes and a saturating match count.
//
// state   | meaning
// FILLING | fewer than PAT_W valid bits held in history; no match possible
// ARMED   | history holds PAT_W valid bits; every valid sample is compared
module seq_detect_param #(
    parameter int                PAT_W    = 5,
    parameter logic [PAT_W-1:0]  PAT_INIT = 5'b10010,
    parameter int                CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_vld,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [PAT_W-1:0]   history_q, history_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [FW-1:0]      fill_inc;
    logic               match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILLING;
            pattern_q <= PAT_INIT;
            history_q <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        pattern_d  = pattern_q;
        history_d  = history_q;
        fill_d     = fill_q;
        match      = 1'b0;
        hist_shift = {history_q[PAT_W-2:0], din};
        fill_inc   = (state_q == ARMED) ? FILL_MAX : fill_q + 1'b1;

        // A load discards any coincident sample and restarts the fill.
        if (pat_load) begin
            pattern_d = pat_in;
            history_d = '0;
            fill_d    = '0;
        end else if (din_vld) begin
            history_d = hist_shift;
            fill_d    = fill_inc;
            if ((fill_inc == FILL_MAX) && (hist_shift == pattern_q)) begin
                match = 1'b1;
                if (!overlap) begin
                    fill_d = '0;
                end
            end
        end

        state_d = (fill_d == FILL_MAX) ? ARMED : FILLING;
        dout_d  = match;

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default-width instance plus a 2-bit-counter
// instance sharing the same stimulus for the saturation case.
`timescale 1ns/1ps
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic       pat_load;
    logic [4:0] pat_in;
    logic       overlap;
    logic       cnt_clr;
    logic       dout;
    logic [7:0] match_cnt;
    logic       dout2;
    logic [1:0] match_cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [23:0] STREAM = 24'b1100_1001_0000_1001_0100_0000;

    seq_detect_param #(.PAT_W(5), .PAT_INIT(5'b10010), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
        .dout(dout), .match_cnt(match_cnt)
    );

    seq_detect_param #(.PAT_W(5), .PAT_INIT(5'b10010), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
        .dout(dout2), .match_cnt(match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic b, input logic v, input logic ld, input logic clr);
        @(negedge clk);
        din      = b;
        din_vld  = v;
        pat_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        din_vld  = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        din      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; din = 1'b0; din_vld = 1'b0; pat_load = 1'b0;
        pat_in = 5'b0; overlap = 1'b1; cnt_clr = 1'b0;
        #1 rst = 1'b1;
        #2;
        total_cnt++;
        if (dout !== 1'b0) $display("FAIL reset_dout: got %b want 0", dout);
        else pass_cnt++;
        total_cnt++;
        if (match_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream(input logic ovl);
        logic [23:0] s;
        logic        e;
        s = STREAM;
        do_reset();
        overlap = ovl;
        for (int i = 0; i < 24; i++) begin
            step(s[23-i], 1'b1, 1'b0, 1'b0);
            e = (i + 1 == 6) || (i + 1 == 17) || (ovl && (i + 1 == 9));
            total_cnt++;
            if (dout !== e) $display("FAIL stream_ovl%0d_dout sample %0d: got %b want %b", ovl, i + 1, dout, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (match_cnt !== (ovl ? 8'd3 : 8'd2))
            $display("FAIL stream_ovl%0d_cnt: got %0d want %0d", ovl, match_cnt, ovl ? 3 : 2);
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        logic [23:0] s;
        logic        e;
        s = STREAM;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(s[23-i], 1'b1, 1'b0, 1'b0);
            e = (i + 1 == 6) || (i + 1 == 9) || (i + 1 == 17);
            total_cnt++;
            if (dout !== e) $display("FAIL gapped_dout valid %0d: got %b want %b", i + 1, dout, e);
            else pass_cnt++;
            step(~s[23-i], 1'b0, 1'b0, 1'b0);
            total_cnt++;
            if (dout !== 1'b0) $display("FAIL gapped_idle_dout after %0d: got %b want 0", i + 1, dout);
            else pass_cnt++;
        end
        total_cnt++;
        if (match_cnt !== 8'd3) $display("FAIL gapped_cnt: got %0d want 3", match_cnt);
        else pass_cnt++;
    endtask

    task automatic test_pat_load();
        logic e;
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        pat_in = 5'b11111;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (dout !== 1'b0) $display("FAIL load_edge_dout: got %b want 0", dout);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            e = (i + 1 >= 5);
            total_cnt++;
            if (dout !== e) $display("FAIL load_dout sample %0d: got %b want %b", i + 1, dout, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (match_cnt !== 8'd3) $display("FAIL load_cnt: got %0d want 3", match_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturate_clr();
        do_reset();
        overlap = 1'b1;
        pat_in  = 5'b11111;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (match_cnt2 !== 2'd3) $display("FAIL sat_cnt2: got %0d want 3", match_cnt2);
        else pass_cnt++;
        total_cnt++;
        if (match_cnt !== 8'd5) $display("FAIL sat_cnt8: got %0d want 5", match_cnt);
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total_cnt++;
        if (dout !== 1'b1) $display("FAIL clr_dout: got %b want 1", dout);
        else pass_cnt++;
        total_cnt++;
        if (match_cnt !== 8'd0) $display("FAIL clr_cnt: got %0d want 0", match_cnt);
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (match_cnt !== 8'd1) $display("FAIL post_clr_cnt: got %0d want 1", match_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        logic [4:0] p;
        logic       e;
        p = 5'b10010;
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 5; i++) step(p[4-i], 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (dout !== 1'b1 || match_cnt !== 8'd1)
            $display("FAIL pre_rst_match: got dout=%b cnt=%0d want dout=1 cnt=1", dout, match_cnt);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) step(p[4-i], 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        din_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (dout !== 1'b0 || match_cnt !== 8'd0)
            $display("FAIL async_rst: got dout=%b cnt=%0d want dout=0 cnt=0", dout, match_cnt);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(p[4-i], 1'b1, 1'b0, 1'b0);
            e = (i == 4);
            total_cnt++;
            if (dout !== e) $display("FAIL post_rst_dout sample %0d: got %b want %b", i + 1, dout, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (match_cnt !== 8'd1) $display("FAIL post_rst_cnt: got %0d want 1", match_cnt);
        else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream(1'b1);
        test_stream(1'b0);
        test_gapped();
        test_pat_load();
        test_saturate_clr();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector: next generation of the fixed 10010 detector. Samples a 1-bit stream under a valid qualifier and compares the most recent PAT_W bits against a runtime-loadable pattern. Emits a one-cycle match pulse and keeps a saturating match count. Selectable overlapping or non-overlapping detection. Sits between a serial data source and downstream control logic.

## Interface
- PAT_W, 5, pattern length in bits; legal range 2..32
- PAT_INIT, 5'b10010, pattern value after reset (PAT_W bits)
- CNT_W, 8, width of the match counter
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data bit
- din_vld  in  1  din is sampled only on edges where din_vld=1
- pat_load  in  1  load pat_in into the pattern register
- pat_in  in  PAT_W  new pattern; first-received bit is the MSB
- overlap  in  1  1: overlapping detection; 0: non-overlapping
- cnt_clr  in  1  synchronous clear of match_cnt
- dout  out  1  one-cycle match pulse, registered
- match_cnt  out  CNT_W  saturating count of matches since reset/clear

## Operation
- Registers:
  - pattern: PAT_W bits.
  - history: PAT_W-bit shift register; new bit enters at the LSB, oldest bit at the MSB.
  - fill: 0..PAT_W, counts valid bits held in history.
- Reset (async, rst=1):
  - pattern=PAT_INIT, history=0, fill=0, dout=0, match_cnt=0.
- Sample edge (din_vld=1, pat_load=0):
  - history_next = {history[PAT_W-2:0], din}.
  - fill_next = min(fill+1, PAT_W).
  - Match condition: fill_next==PAT_W and history_next==pattern.
  - On match: dout=1 for exactly one cycle.
  - On match with overlap=0: fill is forced to 0 (history bits are invalidated), so the next match needs PAT_W fresh bits.
  - On match with overlap=1: fill stays at PAT_W.
- Idle edge (din_vld=0): history and fill hold; dout=0.
- pat_load=1:
  - pattern=pat_in, history=0, fill=0, dout=0.
  - A din_vld sample in the same cycle is discarded (load wins).
- match_cnt:
  - Increments by 1 on each dout assertion.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 sets it to 0; clear wins over a simultaneous match (result is 0, dout still pulses).
- An overlap change takes effect on the next sample edge; it is not retroactive to the current history.
- Equivalent FSM view: states FILLING (fill<PAT_W) and ARMED (fill==PAT_W).
  - FILLING -> ARMED when the PAT_W-th valid bit is sampled.
  - ARMED -> FILLING on a non-overlapping match or on pat_load.
  - Any state -> FILLING on rst.

## Timing
- Latency: dout rises on the same clock edge that samples the final pattern bit; it is high for that one cycle only.
- match_cnt updates on the same edge as dout.
- Back-to-back matches with overlap=1: a period-P pattern can pulse every P valid samples; an all-ones pattern pulses on every valid sample once armed.
- After reset or pat_load, no match is possible until PAT_W valid samples have been taken.
- Reset mid-stream: all state clears immediately (asynchronous), and a partially received pattern is lost.
- A zero pattern only matches after PAT_W received zeros; reset contents of history never produce a match.

## Test plan
- Continuous valid stream of 24'b1100_1001_0000_1001_0100_0000, MSB first, with default pattern and overlap=1 -> dout pulses at samples 6, 9 and 17 (1-based); match_cnt=3.
- Same stream with overlap=0 -> dout pulses at samples 6 and 17; match_cnt=2.
- Same stream with din_vld toggled 1/0 every cycle -> identical pulse sequence, now in terms of valid samples only; dout is never high on a din_vld=0 edge.
- pat_load with pat_in=5'b11111 during stream 1111111 (overlap=1) -> pulses on valid samples 5, 6 and 7; a pat_load coincident with a sample discards that bit.
- CNT_W=2 with 5 matches -> match_cnt saturates at 3. cnt_clr on a match edge -> match_cnt=0 while dout=1.
- rst asserted between samples 3 and 4 of a partial 10010 -> all outputs are 0 immediately; a complete 10010 sent afterwards gives exactly one pulse.
